hiscore_xfer_ctrl: RTL and testbench

- Initiator for the video block's hiscore/pause port (PAUSE_N, HSAD, HSDI, HSWE, HSDO).
- Freezes the game CPU, then dumps a window of sprite-attribute RAM to a byte stream (save) or loads it from a byte stream (restore).
- Sits between the framework's hiscore/NVRAM stream and the video block's sprite-RAM port mux.

---
 rtl/hiscore_xfer_ctrl_if.sv | 24 ++
 rtl/hiscore_xfer_ctrl.sv | 75 +++++++
 tb/tb_hiscore_xfer_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hiscore_xfer_ctrl_if.sv
// hiscore_xfer_ctrl_if: transfer control, byte streams and hiscore/pause RAM port of the controller
interface hiscore_xfer_ctrl_if #(parameter int LEN_W = 12);
  logic start_dump, start_load, abort;
  logic [15:0] base_ad;
  logic [LEN_W-1:0] length;
  logic [7:0] out_data;
  logic out_valid, out_ready;
  logic [7:0] in_data;
  logic in_valid, in_ready;
  logic busy, done;
  logic PAUSE_N;
  logic [15:0] HSAD;
  logic [7:0] HSDI;
  logic HSWE;
  logic [7:0] HSDO;
  modport master (
    input start_dump, start_load, abort, base_ad, length, out_ready, in_data, in_valid, HSDO,
    output out_data, out_valid, in_ready, busy, done, PAUSE_N, HSAD, HSDI, HSWE
  );
  modport slave (
    output start_dump, start_load, abort, base_ad, length, out_ready, in_data, in_valid, HSDO,
    input out_data, out_valid, in_ready, busy, done, PAUSE_N, HSAD, HSDI, HSWE
  );
endinterface

// File: rtl/hiscore_xfer_ctrl.sv
// hiscore_xfer_ctrl: freezes the CPU and dumps/loads a sprite-RAM window over the hiscore port
module hiscore_xfer_ctrl #(
  parameter int SETTLE = 4,
  parameter int RD_LAT = 1,
  parameter int LEN_W = 12
) (
  input logic clk,
  input logic RESET,
  hiscore_xfer_ctrl_if.master hs
);
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_LD_ACC, S_LD_WR, S_FINISH
  } state_t;
  localparam logic [7:0] SETTLE_END = 8'(SETTLE - 1);
  localparam logic [7:0] LAT_END = 8'(RD_LAT - 1);
  state_t state, state_n;
  logic dump, last, step;
  logic [15:0] addr;
  logic [LEN_W-1:0] len, idx;
  logic [7:0] cnt, rdata, wdata;
  assign last = idx + LEN_W'(1) == len;
  // a byte is retired when RD_OUT or LD_WR moves on without being aborted
  assign step = (state == S_RD_OUT || state == S_LD_WR) && state_n != state && state_n != S_IDLE;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (hs.start_dump || hs.start_load) state_n = hs.length == '0 ? S_FINISH : S_SETTLE;
      S_SETTLE:  if (cnt == SETTLE_END) state_n = dump ? S_RD_ADDR : S_LD_ACC;
      S_RD_ADDR: state_n = S_RD_WAIT;
      S_RD_WAIT: if (cnt == LAT_END) state_n = S_RD_OUT;
      S_RD_OUT:  if (hs.out_ready) state_n = last ? S_FINISH : S_RD_ADDR;
      S_LD_ACC:  if (hs.in_valid) state_n = S_LD_WR;
      S_LD_WR:   state_n = last ? S_FINISH : S_LD_ACC;
      S_FINISH:  state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
    if (hs.abort && state != S_IDLE) state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= S_IDLE;
      dump <= 1'b0;
      addr <= '0;
      len <= '0;
      idx <= '0;
      cnt <= '0;
      rdata <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 8'd0 : cnt + 8'd1;
      if (state == S_IDLE && state_n != S_IDLE) begin
        dump <= hs.start_dump;
        addr <= hs.base_ad;
        len <= hs.length;
        idx <= '0;
      end
      if (state == S_RD_WAIT && state_n == S_RD_OUT) rdata <= hs.HSDO;
      if (state == S_LD_ACC && state_n == S_LD_WR) wdata <= hs.in_data;
      if (step) begin
        idx <= idx + LEN_W'(1);
        addr <= addr + 16'd1;
      end
    end
  end
  assign hs.PAUSE_N = state == S_IDLE || state == S_FINISH;
  assign hs.busy = !hs.PAUSE_N;
  assign hs.done = state == S_FINISH;
  assign hs.out_valid = state == S_RD_OUT;
  assign hs.in_ready = state == S_LD_ACC;
  assign hs.HSWE = state == S_LD_WR;
  assign hs.HSAD = addr;
  assign hs.HSDI = wdata;
  assign hs.out_data = rdata;
endmodule

// File: tb/tb_hiscore_xfer_ctrl.sv
// tb_hiscore_xfer_ctrl: directed dump/load scenarios checked against a transfer-level model
module tb_hiscore_xfer_ctrl;
  localparam int SETTLE = 4;
  localparam int RD_LAT = 1;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;
  hiscore_xfer_ctrl_if #(.LEN_W(12)) hs();
  hiscore_xfer_ctrl #(.SETTLE(SETTLE), .RD_LAT(RD_LAT), .LEN_W(12)) dut (.clk(clk), .RESET(RESET), .hs(hs));
  logic [7:0] mem [0:65535];
  int n_chk = 0, n_fail = 0;
  int low_cnt, done_cnt, we_cnt, m_len, m_cnt, w;
  logic [7:0] got[$];
  logic [15:0] rd_ad[$];
  logic [7:0] wq[$];
  bit m_active, m_dump, rst_pend, stall, exp_done, rise_at_done;
  bit prev_pn = 1'b1;
  logic [15:0] m_base;
  logic [7:0] stall_data;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // registered-read sprite RAM with one cycle of read latency
  always @(posedge clk) if (hs.HSWE) mem[hs.HSAD] = hs.HSDI;
  always @(posedge clk) hs.HSDO <= mem[hs.HSAD];

  // transfer-level model: a started transfer owns the port until its length is consumed or aborted
  always @(negedge clk) begin
    if (rst_pend) begin
      chk("rst_PAUSE_N", hs.PAUSE_N, 1); chk("rst_HSWE", hs.HSWE, 0);
      chk("rst_HSAD", hs.HSAD, 0); chk("rst_HSDI", hs.HSDI, 0);
      chk("rst_out_valid", hs.out_valid, 0); chk("rst_out_data", hs.out_data, 0);
      chk("rst_in_ready", hs.in_ready, 0); chk("rst_busy", hs.busy, 0); chk("rst_done", hs.done, 0);
    end
    rst_pend = RESET;
    if (RESET) begin
      m_active = 0; stall = 0; prev_pn = 1; wq.delete();
    end else begin
      exp_done = m_active && m_cnt == m_len;
      chk("done", hs.done, exp_done);
      chk("busy", hs.busy, m_active && m_cnt < m_len);
      chk("PAUSE_N", hs.PAUSE_N, !(m_active && m_cnt < m_len));
      chk("out_valid_scope", hs.out_valid && !(m_active && m_dump), 0);
      chk("in_ready_scope", hs.in_ready && !(m_active && !m_dump), 0);
      chk("HSWE_scope", hs.HSWE && !(m_active && !m_dump), 0);
      if (stall) begin
        chk("stall_valid", hs.out_valid, 1);
        chk("stall_data", hs.out_data, stall_data);
      end
      stall = hs.out_valid && !hs.out_ready && !hs.abort;
      stall_data = hs.out_data;
      if (hs.out_valid && hs.out_ready && !hs.abort) begin
        chk("out_data", hs.out_data, mem[16'(m_base + m_cnt)]);
        got.push_back(hs.out_data);
        rd_ad.push_back(hs.HSAD);
        m_cnt++;
      end
      if (hs.HSWE) begin
        chk("HSAD_wr", hs.HSAD, 16'(m_base + m_cnt));
        if (wq.size() == 0) chk("HSWE_without_byte", 1, 0);
        else chk("HSDI", hs.HSDI, wq.pop_front());
        we_cnt++;
        m_cnt++;
      end
      if (hs.in_valid && hs.in_ready && !hs.abort) wq.push_back(hs.in_data);
      if (!hs.PAUSE_N) low_cnt++;
      if (hs.done) begin
        done_cnt++;
        rise_at_done = hs.PAUSE_N && !prev_pn;
      end
      prev_pn = hs.PAUSE_N;
      if (exp_done) m_active = 0;
      else if (m_active && hs.abort) begin
        m_active = 0; wq.delete();
      end else if (!m_active && (hs.start_dump || hs.start_load)) begin
        m_active = 1; m_dump = hs.start_dump; m_base = hs.base_ad; m_len = int'(hs.length); m_cnt = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic clr();
    low_cnt = 0; done_cnt = 0; we_cnt = 0; got.delete(); rd_ad.delete();
  endtask
  task automatic start(input bit d, input bit l, input logic [15:0] b, input logic [11:0] n);
    hs.start_dump = d; hs.start_load = l; hs.base_ad = b; hs.length = n;
    cyc(1);
    hs.start_dump = 0; hs.start_load = 0;
  endtask
  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) cyc(1);
    chk("done_seen", done_cnt != 0, 1);
    cyc(2);
  endtask
  task automatic wait_ov(input int lim, output int n);
    n = 0;
    while (!hs.out_valid && n < lim) begin cyc(1); n++; end
    chk("out_valid_seen", hs.out_valid, 1);
  endtask
  task automatic feed(input logic [7:0] b, input int gap, output int n);
    hs.in_valid = 1; hs.in_data = b; n = 0;
    while (!hs.in_ready && n < 100) begin cyc(1); n++; end
    chk("in_ready_seen", hs.in_ready, 1);
    cyc(1);
    hs.in_valid = 0;
    cyc(gap);
  endtask
  task automatic consume(input int n, input int hold);
    int k;
    for (int i = 0; i < n; i++) begin
      wait_ov(100, k);
      cyc(hold);
      hs.out_ready = 1; cyc(1); hs.out_ready = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'h7E;
    mem[16'hFFFF] = 8'h99; mem[16'h0000] = 8'h42;
    hs.start_dump = 0; hs.start_load = 0; hs.abort = 0; hs.base_ad = 0; hs.length = 0;
    hs.out_ready = 1; hs.in_valid = 0; hs.in_data = 0;
    cyc(3);
    RESET = 0;
    chk("init_PAUSE_N", hs.PAUSE_N, 1);
    chk("init_busy", hs.busy, 0);
    // dump of three bytes at full rate
    clr(); start(1, 0, 16'h0010, 12'd3); wait_done(100);
    chk("d_count", got.size(), 3);
    chk("d_b0", got[0], 8'hA5); chk("d_b1", got[1], 8'h3C); chk("d_b2", got[2], 8'h7E);
    chk("d_pause_cycles", low_cnt, 13); chk("d_done", done_cnt, 1); chk("d_we", we_cnt, 0);
    // load of two bytes with in_valid held
    clr(); start(0, 1, 16'h0100, 12'd2);
    feed(8'h11, 0, w); chk("l_first_ready", w, 4);
    feed(8'h22, 0, w); wait_done(50);
    chk("l_mem0", mem[16'h0100], 8'h11); chk("l_mem1", mem[16'h0101], 8'h22);
    chk("l_we", we_cnt, 2); chk("l_done", done_cnt, 1);
    chk("l_pause_cycles", low_cnt, 8); chk("l_done_at_rise", rise_at_done, 1);
    // dump with consumer backpressure
    clr(); hs.out_ready = 0; start(1, 0, 16'h0010, 12'd2); consume(2, 5); hs.out_ready = 1; wait_done(50);
    chk("bp_count", got.size(), 2); chk("bp_b0", got[0], 8'hA5); chk("bp_b1", got[1], 8'h3C);
    chk("bp_done", done_cnt, 1);
    // load with gaps on in_valid
    clr(); start(0, 1, 16'h0200, 12'd2); feed(8'h5A, 3, w); feed(8'hC3, 0, w); wait_done(50);
    chk("gap_mem0", mem[16'h0200], 8'h5A); chk("gap_mem1", mem[16'h0201], 8'hC3); chk("gap_we", we_cnt, 2);
    // address wrap
    clr(); start(1, 0, 16'hFFFF, 12'd2); wait_done(50);
    chk("wrap_b0", got[0], 8'h99); chk("wrap_b1", got[1], 8'h42);
    chk("wrap_ad0", rd_ad[0], 16'hFFFF); chk("wrap_ad1", rd_ad[1], 16'h0000);
    // zero length
    clr(); start(1, 0, 16'h0010, 12'd0);
    chk("z_done_now", hs.done, 1); chk("z_busy", hs.busy, 0);
    cyc(1); chk("z_done_once", hs.done, 0);
    cyc(3); chk("z_pause_cycles", low_cnt, 0); chk("z_done_cnt", done_cnt, 1);
    // abort while the second byte of a four-byte load is being written
    clr(); start(0, 1, 16'h0300, 12'd4); feed(8'h01, 0, w); feed(8'h02, 0, w);
    hs.abort = 1; cyc(1); hs.abort = 0;
    chk("a_PAUSE_N", hs.PAUSE_N, 1); chk("a_busy", hs.busy, 0);
    cyc(5);
    chk("a_we", we_cnt, 2); chk("a_done", done_cnt, 0);
    chk("a_mem1", mem[16'h0301], 8'h02); chk("a_mem2", mem[16'h0302], 8'h00);
    // reset while a byte is waiting in RD_OUT
    clr(); hs.out_ready = 0; start(1, 0, 16'h0010, 12'd3); wait_ov(50, w);
    RESET = 1; cyc(1); RESET = 0;
    chk("r_HSAD", hs.HSAD, 0); chk("r_out_valid", hs.out_valid, 0);
    chk("r_out_data", hs.out_data, 0); chk("r_PAUSE_N", hs.PAUSE_N, 1);
    hs.out_ready = 1; cyc(3);
    chk("r_done", done_cnt, 0); chk("r_count", got.size(), 0);
    // simultaneous starts and a start while busy
    clr(); start(1, 1, 16'h0010, 12'd1); cyc(2); start(0, 1, 16'h0500, 12'd1); wait_done(50);
    chk("s_we", we_cnt, 0); chk("s_count", got.size(), 1); chk("s_b0", got[0], 8'hA5);
    chk("s_done", done_cnt, 1); chk("s_pause_cycles", low_cnt, 7);
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
